// File: rtl/oka_pkg.sv
// Shared constants, state encoding and helpers for the
// overlap-free Karatsuba GF(2) multipliers.
package oka_pkg;

  localparam int N  = 10;
  localparam int H  = N / 2;
  localparam int PW = N - 1;
  localparam int OW = 2 * N - 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

  function automatic logic [H-1:0] split_half(
    input logic [N-1:0] v,
    input logic         odd
  );
    logic [H-1:0] r;
    r = '0;
    for (int i = 0; i < H; i++)
      r[i] = v[2*i + (odd ? 1 : 0)];
    return r;
  endfunction

  // Even output bits take P1 and x^2-shifted P4; odd bits take P2^P3.
  function automatic logic [OW-1:0] oka_combine(
    input logic [PW-1:0] p1,
    input logic [PW-1:0] p2,
    input logic [PW-1:0] p3,
    input logic [PW-1:0] p4
  );
    logic [OW-1:0] r;
    r = '0;
    r[0]    = p1[0];
    r[OW-1] = p4[PW-1];
    for (int i = 1; i < PW; i++)
      r[2*i] = p1[i] ^ p4[i-1];
    for (int i = 0; i < PW; i++)
      r[2*i+1] = p2[i] ^ p3[i];
    return r;
  endfunction

endpackage

// File: rtl/clmul_5x5.sv
// Combinational H-by-H carry-less multiplier, shared across
// the four half-products of the sequential OKA.
module clmul_5x5
  import oka_pkg::*;
(
  input  logic [H-1:0]  i_a,
  input  logic [H-1:0]  i_b,
  output logic [PW-1:0] o_p
);

  always_comb begin
    o_p = '0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < H; j++)
        o_p[i+j] = o_p[i+j] ^ (i_a[i] & i_b[j]);
  end

endmodule

// File: rtl/oka_seq_mul10.sv
// Sequential overlap-free Karatsuba 10-bit GF(2) multiplier:
// one 5x5 sub-multiplier time-shared over four cycles.
module oka_seq_mul10
  import oka_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          busy
);

  state_e        r_state;
  state_e        w_next;
  logic [1:0]    r_cnt;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [PW-1:0] r_p1;
  logic [PW-1:0] r_p2;
  logic [PW-1:0] r_p3;
  logic [PW-1:0] r_p4;
  logic [OW-1:0] r_out;

  logic [H-1:0]  w_ae;
  logic [H-1:0]  w_ao;
  logic [H-1:0]  w_be;
  logic [H-1:0]  w_bo;
  logic [H-1:0]  w_x;
  logic [H-1:0]  w_y;
  logic [PW-1:0] w_prod;
  logic          w_acc;
  logic          w_mul;

  assign w_ae = split_half(r_a, 1'b0);
  assign w_ao = split_half(r_a, 1'b1);
  assign w_be = split_half(r_b, 1'b0);
  assign w_bo = split_half(r_b, 1'b1);

  always_comb begin
    w_x = w_ae;
    w_y = w_be;
    unique case (r_cnt)
      2'd0: begin w_x = w_ae; w_y = w_be; end
      2'd1: begin w_x = w_ae; w_y = w_bo; end
      2'd2: begin w_x = w_ao; w_y = w_be; end
      2'd3: begin w_x = w_ao; w_y = w_bo; end
    endcase
  end

  clmul_5x5 u_mul (
    .i_a (w_x),
    .i_b (w_y),
    .o_p (w_prod)
  );

  assign w_acc = (r_state == IDLE) && in_valid;
  assign w_mul = (r_state == MUL);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = MUL;
      MUL:     if (r_cnt == 2'd3) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_p1  <= '0;
      r_p2  <= '0;
      r_p3  <= '0;
      r_p4  <= '0;
      r_out <= '0;
    end else begin
      if (w_acc) begin
        r_a   <= a;
        r_b   <= b;
        r_cnt <= '0;
      end
      if (w_mul) begin
        r_cnt <= r_cnt + 2'd1;
        unique case (r_cnt)
          2'd0: r_p1 <= w_prod;
          2'd1: r_p2 <= w_prod;
          2'd2: r_p3 <= w_prod;
          2'd3: r_p4 <= w_prod;
        endcase
        // P4 is still in flight on the last edge; use it live.
        if (r_cnt == 2'd3)
          r_out <= oka_combine(r_p1, r_p2, r_p3, w_prod);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_out;

endmodule

// File: tb/tb_oka_seq_mul10.sv
// Bench for oka_seq_mul10: fixed vectors, backpressure,
// mid-op reset and randomised handshakes against a GF(2) model.
module tb_oka_seq_mul10;

  localparam int NRAND = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  a = '0;
  logic [9:0]  b = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [18:0] out_data;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;
  int n_out  = 0;
  int n_drop = 0;
  logic [18:0] exp_q[$];

  typedef struct {
    logic [9:0]  va;
    logic [9:0]  vb;
    logic [18:0] ve;
  } vec_t;

  always #5 clk = ~clk;

  oka_seq_mul10 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [18:0] clmul_ref(
    input logic [9:0] x,
    input logic [9:0] y
  );
    logic [18:0] r;
    r = '0;
    for (int i = 0; i < 10; i++)
      if (y[i]) r = r ^ (19'(x) << i);
    return r;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Scoreboard sampling sits on the falling edge, between drives.
  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready) begin
      exp_q.push_back(clmul_ref(a, b));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_out++;
      chk("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("product", 32'(out_data), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_vec(
    input logic [9:0]  va,
    input logic [9:0]  vb,
    input logic [18:0] ve,
    input string       nm
  );
    int lat;
    out_ready = 1'b1;
    a = va;
    b = vb;
    in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, "_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk({nm, "_lat"}, 32'(lat), 32'd4);
    chk({nm, "_data"}, 32'(out_data), 32'(ve));
    step();
    chk({nm, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t vt[6];
    int lat;
    int bp_bad;
    int start;
    int cyc;
    logic [18:0] exp_a;

    vt[0] = '{10'h001, 10'h001, 19'h00001};
    vt[1] = '{10'h003, 10'h003, 19'h00005};
    vt[2] = '{10'h3FF, 10'h3FF, 19'h55555};
    vt[3] = '{10'h200, 10'h200, 19'h40000};
    vt[4] = '{10'h3FF, 10'h001, 19'h003FF};
    vt[5] = '{10'h002, 10'h200, 19'h00400};

    @(posedge clk);
    #1;
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++)
      run_vec(vt[i].va, vt[i].vb, vt[i].ve, $sformatf("vec%0d", i));

    // Backpressure: product held, second offer ignored meanwhile.
    out_ready = 1'b0;
    a = 10'h155;
    b = 10'h2AB;
    exp_a = clmul_ref(10'h155, 10'h2AB);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_lat", 32'(lat), 32'd4);
    a = 10'h0F3;
    b = 10'h1C7;
    in_valid = 1'b1;
    bp_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_data !== exp_a || in_ready !== 1'b0 || out_valid !== 1'b1)
        bp_bad++;
    end
    chk("bp_hold", 32'(bp_bad), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp_second_lat", 32'(lat), 32'd4);
    chk("bp_second_data", 32'(out_data), 32'(clmul_ref(10'h0F3, 10'h1C7)));
    step();

    // Reset while the third half-product is being formed.
    a = 10'h3A5;
    b = 10'h1C3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    n_drop++;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    chk("mid_rel_valid", 32'(out_valid), 32'd0);
    run_vec(10'h2B7, 10'h19D, clmul_ref(10'h2B7, 10'h19D), "post_rst");

    start = n_acc;
    cyc = 0;
    while ((n_acc - start) < NRAND && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a = 10'($urandom);
      b = 10'($urandom);
      step();
      cyc++;
    end
    chk("rand_count", 32'(n_acc - start), 32'(NRAND));
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("no_drop_dup", 32'(n_out), 32'(n_acc - n_drop));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
